// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module : seg_scan_mux
// Brief  : Four-digit seven-segment scanner with dead-time and frame latching.
// Rev    : 1.0  initial release
// ============================================================================
module seg_scan_mux #(
   parameter int BLANK_CYC = 16,
   parameter int SHOW_CYC  = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [27:0] D,
   input  logic [3:0]  AN_in,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam int c_max_cyc = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
   localparam int c_cw      = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;
   localparam logic [c_cw-1:0] c_blank_last = c_cw'(BLANK_CYC - 1);
   localparam logic [c_cw-1:0] c_show_last  = c_cw'(SHOW_CYC - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_BLANK = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   state_t          r_state;
   logic [1:0]      r_idx;
   logic [c_cw-1:0] r_cnt;
   logic [6:0]      r_pat [4];
   logic [3:0]      r_sup;
   logic [6:0]      r_seg;
   logic [3:0]      r_an;
   logic            r_fs;

   state_t          w_state;
   logic [1:0]      w_idx;
   logic [c_cw-1:0] w_cnt;
   logic            w_cap;
   logic [6:0]      w_seg;
   logic [3:0]      w_an;
   logic            w_fs;

   // Outputs are registered from the next state so they match the state held
   // in the same cycle. A LOAD whose frame_start is low (after reset or a
   // freeze) has not yet been presented, so it is re-run before capturing.
   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_cnt   = r_cnt;
      w_cap   = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_idx = 2'd0;
            w_cnt = '0;
            if (r_fs) begin
               w_cap   = 1'b1;
               w_state = S_BLANK;
            end
         end
         S_BLANK: begin
            if (r_cnt == c_blank_last) begin
               w_state = S_SHOW;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_SHOW: begin
            if (r_cnt == c_show_last) begin
               w_cnt = '0;
               if (r_idx == 2'd3) begin
                  w_state = S_LOAD;
                  w_idx   = 2'd0;
               end else begin
                  w_state = S_BLANK;
                  w_idx   = r_idx + 1'b1;
               end
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state = S_LOAD;
            w_idx   = 2'd0;
            w_cnt   = '0;
         end
      endcase

      w_fs  = (w_state == S_LOAD);
      w_seg = 7'h7f;
      w_an  = 4'hf;
      if (w_state == S_SHOW) begin
         w_seg = r_pat[w_idx];
         if (!r_sup[w_idx]) begin
            w_an = ~(4'b0001 << w_idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_LOAD;
         r_idx   <= 2'd0;
         r_cnt   <= '0;
         for (int k = 0; k < 4; k++) begin
            r_pat[k] <= 7'h7f;
         end
         r_sup   <= 4'hf;
         r_seg   <= 7'h7f;
         r_an    <= 4'hf;
         r_fs    <= 1'b0;
      end else if (en) begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_cnt   <= w_cnt;
         if (w_cap) begin
            for (int k = 0; k < 4; k++) begin
               r_pat[k] <= D[7*k +: 7];
            end
            r_sup <= AN_in;
         end
         r_seg   <= w_seg;
         r_an    <= w_an;
         r_fs    <= w_fs;
      end else begin
         r_seg   <= 7'h7f;
         r_an    <= 4'hf;
         r_fs    <= 1'b0;
      end
   end

   assign seg         = r_seg;
   assign an          = r_an;
   assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_seg_scan_mux
// Brief  : Self-checking bench: vector table, corner sequences, random model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seg_scan_mux;

   localparam int c_b      = 2;
   localparam int c_s      = 3;
   localparam int c_slot   = c_b + c_s;
   localparam int c_period = 1 + 4 * c_slot;
   localparam logic [27:0] c_da = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] c_db = {7'h00, 7'h78, 7'h02, 7'h12};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [27:0] D = '0;
   logic [3:0]  AN_in = '0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   // Reference model: position within the frame plus latched frame contents.
   int         m_p    = 0;
   bit         m_pend = 1'b1;
   bit         m_live = 1'b0;
   logic [6:0] m_pat [4];
   logic [3:0] m_sup = 4'hf;
   logic       prev_fs = 1'b0;

   typedef struct {
      int         lo;
      int         hi;
      logic [3:0] an_in;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_fs;
   } vec_t;

   vec_t tbl [20];

   seg_scan_mux #(
      .BLANK_CYC (c_b),
      .SHOW_CYC  (c_s)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .D           (D),
      .AN_in       (AN_in),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [27:0] d, input logic [3:0] a);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_fs;
      int         q;
      int         k;
      rst_n = r;
      en    = e;
      D     = d;
      AN_in = a;
      @(posedge clk);
      if (!r) begin
         m_pend = 1'b1;
         m_live = 1'b0;
         m_p    = 0;
         for (int i = 0; i < 4; i++) m_pat[i] = 7'h7f;
         m_sup  = 4'hf;
      end else if (!e) begin
         if (m_p == 0) m_pend = 1'b1;
         m_live = 1'b0;
      end else begin
         m_live = 1'b1;
         if (m_pend) begin
            m_pend = 1'b0;
         end else begin
            if (m_p == 0) begin
               for (int i = 0; i < 4; i++) m_pat[i] = d[7*i +: 7];
               m_sup = a;
            end
            m_p = (m_p + 1) % c_period;
         end
      end
      e_an  = 4'hf;
      e_seg = 7'h7f;
      e_fs  = 1'b0;
      if (m_live) begin
         if (m_p == 0) begin
            e_fs = 1'b1;
         end else begin
            q = m_p - 1;
            k = q / c_slot;
            if ((q % c_slot) >= c_b) begin
               e_seg = m_pat[k];
               e_an  = m_sup[k] ? 4'hf : ~(4'b0001 << k);
            end
         end
      end
      #1;
      chk("model_seg", seg, e_seg);
      chk("model_an", an, e_an);
      chk("model_fs", frame_start, e_fs);
      chk("an_single", ($countones(~an) <= 1), 1);
      chk("fs_double", prev_fs & frame_start, 0);
      prev_fs = frame_start;
   endtask

   task automatic reset_dut();
      step(1'b0, 1'b1, c_da, 4'h0);
      step(1'b0, 1'b1, c_da, 4'h0);
   endtask

   initial begin
      logic        r;
      logic        e;
      logic [27:0] rd;
      logic [3:0]  ra;

      tbl[0]  = '{0,  0,  4'h0, 4'hf, 7'h7f, 1'b1};
      tbl[1]  = '{1,  2,  4'h0, 4'hf, 7'h7f, 1'b0};
      tbl[2]  = '{3,  5,  4'h0, 4'he, 7'h19, 1'b0};
      tbl[3]  = '{6,  7,  4'h0, 4'hf, 7'h7f, 1'b0};
      tbl[4]  = '{8,  10, 4'h0, 4'hd, 7'h30, 1'b0};
      tbl[5]  = '{11, 12, 4'h0, 4'hf, 7'h7f, 1'b0};
      tbl[6]  = '{13, 15, 4'h0, 4'hb, 7'h24, 1'b0};
      tbl[7]  = '{16, 17, 4'h0, 4'hf, 7'h7f, 1'b0};
      tbl[8]  = '{18, 20, 4'h0, 4'h7, 7'h79, 1'b0};
      tbl[9]  = '{21, 21, 4'hc, 4'hf, 7'h7f, 1'b1};
      tbl[10] = '{22, 23, 4'hc, 4'hf, 7'h7f, 1'b0};
      tbl[11] = '{24, 26, 4'hc, 4'he, 7'h19, 1'b0};
      tbl[12] = '{27, 28, 4'hc, 4'hf, 7'h7f, 1'b0};
      tbl[13] = '{29, 31, 4'hc, 4'hd, 7'h30, 1'b0};
      tbl[14] = '{32, 33, 4'hc, 4'hf, 7'h7f, 1'b0};
      tbl[15] = '{34, 36, 4'hc, 4'hf, 7'h24, 1'b0};
      tbl[16] = '{37, 38, 4'hc, 4'hf, 7'h7f, 1'b0};
      tbl[17] = '{39, 41, 4'hc, 4'hf, 7'h79, 1'b0};
      tbl[18] = '{42, 42, 4'hc, 4'hf, 7'h7f, 1'b1};
      tbl[19] = '{43, 44, 4'h0, 4'hf, 7'h7f, 1'b0};

      for (int i = 0; i < 4; i++) m_pat[i] = 7'h7f;

      // Basic scan then a suppressed frame
      reset_dut();
      chk("reset_an", an, 4'hf);
      chk("reset_seg", seg, 7'h7f);
      chk("reset_fs", frame_start, 0);
      for (int i = 0; i < 20; i++) begin
         for (int c = tbl[i].lo; c <= tbl[i].hi; c++) begin
            step(1'b1, 1'b1, c_da, tbl[i].an_in);
            chk("tbl_an", an, tbl[i].exp_an);
            chk("tbl_seg", seg, tbl[i].exp_seg);
            chk("tbl_fs", frame_start, tbl[i].exp_fs);
         end
      end

      // New data mid-frame only shows after the next LOAD
      reset_dut();
      for (int t = 0; t <= 26; t++) begin
         step(1'b1, 1'b1, (t < 10) ? c_da : c_db, 4'h0);
         if (t == 18 || t == 20) chk("tear_old_seg", seg, 7'h79);
         if (t == 21) chk("tear_load_fs", frame_start, 1);
         if (t == 24) chk("tear_new_seg", seg, 7'h12);
      end

      // Freeze in the middle of digit 0's SHOW slot
      reset_dut();
      for (int t = 0; t <= 28; t++) begin
         step(1'b1, !(t >= 5 && t <= 10), c_da, 4'h0);
         if (t >= 5 && t <= 10) chk("en_blank_an", an, 4'hf);
         if (t == 11) chk("en_resume_an", an, 4'he);
         if (t == 12) chk("en_after_an", an, 4'hf);
         if (t >= 1 && t <= 26) chk("en_no_fs", frame_start, 0);
         if (t == 27) chk("en_frame_len", frame_start, 1);
      end

      // Reset mid-frame restarts the timing
      reset_dut();
      for (int t = 0; t <= 24; t++) begin
         step(!(t == 15 || t == 16), 1'b1, c_da, 4'h0);
         if (t == 15 || t == 16) begin
            chk("rst_mid_an", an, 4'hf);
            chk("rst_mid_fs", frame_start, 0);
         end
         if (t == 17) chk("rst_release_fs", frame_start, 1);
         if (t == 19) chk("rst_blank_an", an, 4'hf);
         if (t == 20) chk("rst_digit0_an", an, 4'he);
      end

      // Freeze during LOAD re-runs LOAD and captures the later data
      reset_dut();
      for (int t = 0; t <= 28; t++) begin
         step(1'b1, !(t == 22 || t == 23), (t < 22) ? c_da : c_db, 4'h0);
         if (t == 22) chk("load_freeze_fs", frame_start, 0);
         if (t == 24) chk("load_rerun_fs", frame_start, 1);
         if (t == 25) chk("load_exit_fs", frame_start, 0);
         if (t == 27) chk("load_new_seg", seg, 7'h12);
      end

      // Randomized run against the model
      rd = c_da;
      ra = 4'h0;
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 299) != 0);
         e = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 19) == 0) rd = 28'($urandom);
         if ($urandom_range(0, 19) == 0) ra = 4'($urandom);
         step(r, e, rd, ra);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
